// File: rtl/proc_ctrl_pkg.sv
// Shared control encodings for the 16-bit multi-cycle processor: FSM states,
// opcodes and the ALU / mux select codes used by the control and datapath.
package proc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_RD    = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WR    = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11,
        HALT      = 4'd12,
        ERROR     = 4'd13
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SW    = 4'b0010;
    localparam logic [3:0] OP_BEQ   = 4'b0011;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_J     = 4'b0101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIFT = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multi_cycle_control.sv
// Main control FSM of the multi-cycle processor: sequences fetch, decode,
// execute, memory and write-back, and counts retired instructions.
module multi_cycle_control
    import proc_ctrl_pkg::*;
#(
    parameter int RETIRE_W = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [3:0]          opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                ir_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                i_or_d,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic [3:0]          state,
    output logic                halted,
    output logic                error,
    output logic [RETIRE_W-1:0] retired
);

    localparam logic [RETIRE_W-1:0] RETIRE_ONE = RETIRE_W'(1);

    state_t                state_q, state_d;
    logic   [3:0]          op_q;
    logic   [RETIRE_W-1:0] retired_q;

    // An instruction retires whenever control returns to FETCH from elsewhere.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= FETCH;
            op_q      <= 4'd0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE)
                op_q <= opcode;
            if (state_q != FETCH && state_d == FETCH)
                retired_q <= retired_q + RETIRE_ONE;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        halted        = 1'b0;
        error         = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_ONE;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready)
                    state_d = DECODE;
            end
            // The live opcode is only trusted here; later states use op_q.
            DECODE: begin
                alu_src_b = SRCB_SHIFT;
                case (opcode)
                    OP_RTYPE:     state_d = R_EXEC;
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDI_EXEC;
                    OP_J:         state_d = JUMP;
                    OP_HALT:      state_d = HALT;
                    default:      state_d = ERROR;
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (op_q == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready)
                    state_d = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
            end
            MEM_WR: begin
                i_or_d    = 1'b1;
                mem_write = mem_ready;
                if (mem_ready)
                    state_d = FETCH;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = R_WB;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                state_d       = FETCH;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                state_d   = FETCH;
            end
            ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = ADDI_WB;
            end
            ADDI_WB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            HALT:    halted  = 1'b1;
            ERROR:   error   = 1'b1;
            default: state_d = ERROR;
        endcase
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: directed per-cycle vectors push
// expected state/controls/count, a negedge monitor pops and compares them.
module tb_multi_cycle_control;

    localparam int RW = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [3:0]    opcode = 4'd0;
    logic          mem_ready = 1'b0;
    logic          pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
    logic          reg_write, reg_dst, mem_to_reg, alu_src_a, halted, error;
    logic [1:0]    alu_src_b, alu_op, pc_source;
    logic [3:0]    state;
    logic [RW-1:0] retired;
    logic [17:0]   dutCtrl;

    typedef struct {
        int          id;
        logic [3:0]  st;
        logic [17:0] ctrl;
        logic [RW-1:0] ret;
        bit          chk;
    } exp_t;

    exp_t          sbq[$];
    int            total = 0;
    int            bad = 0;
    int            vecId = 0;
    logic [3:0]    prevSt = 4'd0;
    logic [RW-1:0] expRet = '0;
    bit            pendingRst = 1'b0;

    multi_cycle_control #(.RETIRE_W(RW)) dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .halted(halted), .error(error),
        .retired(retired)
    );

    always #5 clock = ~clock;

    assign dutCtrl = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
                      reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                      pc_source, halted, error};

    // Control word each state must present, as listed per state in the datasheet.
    function automatic logic [17:0] expCtrl(input logic [3:0] s, input logic r);
        logic pw, pwc, irw, mr, mw, iod, rw, rd, m2r, asa, h, e;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, irw, mr, mw, iod, rw, rd, m2r, asa, h, e} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (s)
            4'd0:        begin mr = 1; asb = 2'b01; pw = r; irw = r; end
            4'd1:        asb = 2'b11;
            4'd2, 4'd10: begin asa = 1; asb = 2'b10; end
            4'd3:        begin mr = 1; iod = 1; end
            4'd4:        begin rw = 1; m2r = 1; end
            4'd5:        begin iod = 1; mw = r; end
            4'd6:        begin asa = 1; aop = 2'b10; end
            4'd7:        begin rw = 1; rd = 1; end
            4'd8:        begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            4'd9:        begin pw = 1; psrc = 2'b10; end
            4'd11:       rw = 1;
            4'd12:       h = 1;
            4'd13:       e = 1;
            default:     ;
        endcase
        return {pw, pwc, irw, mr, mw, iod, rw, rd, m2r, asa, asb, aop, psrc, h, e};
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show during it.
    task automatic applyStimulus(input bit rst, input logic [3:0] op, input logic rdy,
                                 input logic [3:0] expSt, input bit chk);
        exp_t e;
        @(posedge clock);
        #1;
        reset_n   = !rst;
        opcode    = op;
        mem_ready = rdy;
        if (pendingRst)
            expRet = '0;
        else if (prevSt != 4'd0 && expSt == 4'd0)
            expRet = expRet + 1'b1;
        pendingRst = rst;
        prevSt     = expSt;
        e.id   = vecId;
        e.st   = expSt;
        e.ctrl = expCtrl(expSt, rdy);
        e.ret  = expRet;
        e.chk  = chk;
        sbq.push_back(e);
        vecId++;
    endtask

    task automatic checkOutput(input exp_t e);
        total++;
        if (state !== e.st) begin
            bad++;
            $display("[TB] FAIL vec%0d state: got %0d want %0d", e.id, state, e.st);
        end
        total++;
        if (dutCtrl !== e.ctrl) begin
            bad++;
            $display("[TB] FAIL vec%0d ctrl (st %0d): got %b want %b", e.id, e.st, dutCtrl, e.ctrl);
        end
        total++;
        if (retired !== e.ret) begin
            bad++;
            $display("[TB] FAIL vec%0d retired: got %0d want %0d", e.id, retired, e.ret);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.chk)
                    checkOutput(e);
            end
        end
    end

    initial begin
        applyStimulus(1, 4'h0, 0, 4'd0, 0);
        // R-type, no waits
        applyStimulus(0, 4'h0, 1, 4'd0, 1);
        applyStimulus(0, 4'h0, 1, 4'd1, 1);
        applyStimulus(0, 4'h0, 1, 4'd6, 1);
        applyStimulus(0, 4'h0, 1, 4'd7, 1);
        // LW with 2 fetch waits and 3 read waits; opcode flips after DECODE
        applyStimulus(0, 4'h1, 0, 4'd0, 1);
        applyStimulus(0, 4'h1, 0, 4'd0, 1);
        applyStimulus(0, 4'h1, 1, 4'd0, 1);
        applyStimulus(0, 4'h1, 1, 4'd1, 1);
        applyStimulus(0, 4'h2, 1, 4'd2, 1);
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 4'h2, 0, 4'd3, 1);
        applyStimulus(0, 4'h2, 1, 4'd3, 1);
        applyStimulus(0, 4'h2, 1, 4'd4, 1);
        // SW with one write wait
        applyStimulus(0, 4'h2, 1, 4'd0, 1);
        applyStimulus(0, 4'h2, 1, 4'd1, 1);
        applyStimulus(0, 4'h1, 1, 4'd2, 1);
        applyStimulus(0, 4'h1, 0, 4'd5, 1);
        applyStimulus(0, 4'h1, 1, 4'd5, 1);
        // BEQ then J
        applyStimulus(0, 4'h3, 1, 4'd0, 1);
        applyStimulus(0, 4'h3, 1, 4'd1, 1);
        applyStimulus(0, 4'h3, 1, 4'd8, 1);
        applyStimulus(0, 4'h5, 1, 4'd0, 1);
        applyStimulus(0, 4'h5, 1, 4'd1, 1);
        applyStimulus(0, 4'h5, 0, 4'd9, 1);
        // Reset while in MEM_RD
        applyStimulus(0, 4'h1, 1, 4'd0, 1);
        applyStimulus(0, 4'h1, 1, 4'd1, 1);
        applyStimulus(0, 4'h1, 1, 4'd2, 1);
        applyStimulus(1, 4'h1, 0, 4'd3, 1);
        applyStimulus(0, 4'h4, 0, 4'd0, 1);
        // 16 ADDIs wrap the 4-bit counter back to 0
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 4'h4, 1, 4'd0, 1);
            applyStimulus(0, 4'h4, 1, 4'd1, 1);
            applyStimulus(0, 4'h4, 1, 4'd10, 1);
            applyStimulus(0, 4'h4, 1, 4'd11, 1);
        end
        // One J so the frozen count during HALT is non-zero
        applyStimulus(0, 4'h5, 1, 4'd0, 1);
        applyStimulus(0, 4'h5, 1, 4'd1, 1);
        applyStimulus(0, 4'h5, 1, 4'd9, 1);
        applyStimulus(0, 4'hF, 1, 4'd0, 1);
        applyStimulus(0, 4'hF, 1, 4'd1, 1);
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 4'(i), 1'(i), 4'd12, 1);
        // Illegal opcode is sticky until reset
        applyStimulus(1, 4'hF, 0, 4'd12, 1);
        applyStimulus(0, 4'hA, 1, 4'd0, 1);
        applyStimulus(0, 4'hA, 1, 4'd1, 1);
        for (int i = 0; i < 20; i++)
            applyStimulus(0, 4'(i), 1'(i), 4'd13, 1);
        applyStimulus(1, 4'h0, 0, 4'd13, 1);
        applyStimulus(0, 4'h0, 0, 4'd0, 1);
        applyStimulus(0, 4'h0, 0, 4'd0, 1);
        @(posedge clock);
        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Main control FSM for the 16-bit multi-cycle processor. Sequences each instruction through fetch, decode, execute, memory and write-back. Drives the register-file, memory, PC and multiplexer enables, and supplies the 2-bit `alu_op` consumed by the ALU control decoder. Sits in the control path beside the datapath and honours a ready handshake from the shared instruction/data memory.

## Interface
- `RETIRE_W`, 16: width of the retired-instruction counter.
- `clock` input 1: single system clock; all state updates on its rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `opcode` input 4: IR[15:12]; valid from the DECODE cycle onward.
- `mem_ready` input 1: memory completes the current read/write this cycle.
- `pc_write`, `pc_write_cond`, `ir_write`, `mem_read`, `mem_write`, `i_or_d`, `reg_write`, `reg_dst`, `mem_to_reg`, `alu_src_a` output 1 each: datapath enables/selects.
- `alu_src_b` output 2: 00 reg B, 01 constant 1, 10 sign-extended imm, 11 shifted imm.
- `alu_op` output 2: 00 add, 01 subtract, 10 use funct.
- `pc_source` output 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `state` output 4: current FSM state, for debug.
- `halted` output 1: sticky, HALT executed.
- `error` output 1: sticky, illegal opcode decoded.
- `retired` output RETIRE_W: count of completed instructions; wraps to 0.

## Operation
- Opcodes:
  - 0000 R-type; 0001 LW; 0010 SW; 0011 BEQ; 0100 ADDI; 0101 J; 1111 HALT.
  - All other opcodes are illegal.
- Opcode handling: the opcode is latched into an internal register in DECODE. Later states use the latched copy only.
- States and encodings:
  - FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5.
  - R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11.
  - HALT 12, ERROR 13. Codes 14–15 are unreachable; if entered, go to ERROR.
- Transitions:
  - FETCH → DECODE when `mem_ready`; otherwise stay in FETCH.
  - DECODE → R_EXEC, MEM_ADDR (LW/SW), BRANCH, ADDI_EXEC, JUMP, HALT or ERROR, by opcode.
  - MEM_ADDR → MEM_RD (LW) or MEM_WR (SW).
  - MEM_RD → MEM_WB on `mem_ready`, else stay. MEM_WR → FETCH on `mem_ready`, else stay.
  - R_EXEC → R_WB. ADDI_EXEC → ADDI_WB.
  - R_WB, MEM_WB, ADDI_WB, BRANCH, JUMP → FETCH.
  - HALT and ERROR are absorbing; only reset leaves them.
- Outputs per state (every output not listed is 0):
  - FETCH: `mem_read`=1, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00. `ir_write` and `pc_write` equal `mem_ready`.
  - DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00.
  - MEM_ADDR and ADDI_EXEC: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - MEM_RD: `mem_read`=1, `i_or_d`=1.
  - MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
  - MEM_WR: `i_or_d`=1, `mem_write`=`mem_ready`.
  - R_EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10.
  - R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0.
  - ADDI_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01.
  - JUMP: `pc_write`=1, `pc_source`=10.
  - HALT: `halted`=1. ERROR: `error`=1.
- Retired counter: `retired` increments by 1 on every transition into FETCH from a non-FETCH state, i.e. each completed instruction. It wraps from all-ones to 0.

## Timing
- Reset: while `reset_n`=0 at a clock edge, the next state is FETCH, `retired`=0 and the latched opcode is 0. All outputs then take their FETCH values.
- Reset mid-instruction: the instruction is abandoned; no partial write is retried.
- Output style: state-decoded (Moore). The exceptions are `ir_write`, `pc_write` (in FETCH) and `mem_write`, which are also gated combinationally by `mem_ready`.
- Zero-wait latency, FETCH to FETCH: R-type 4, LW 5, SW 4, ADDI 4, BEQ 3, J 3 cycles. Each memory wait cycle adds 1.
- `mem_ready` in any state other than FETCH, MEM_RD or MEM_WR is ignored.
- `opcode` changing after DECODE has no effect.

## Structure
- Package `proc_ctrl_pkg`:
  - state enum and encodings;
  - opcode constants;
  - `alu_op` constants ADD=00, SUB=01, FUNCT=10;
  - `alu_src_b` and `pc_source` select constants.
- These constants are shared with the ALU control decoder and the datapath muxes.
- Single module with no sub-modules: the next-state logic, output decode and retired counter are small and tightly coupled.

## Test plan
- **Reset:** hold `reset_n`=0 mid-MEM_RD for 1 cycle → `state`=0, `retired`=0, `mem_read`=1, `reg_write`=0.
- **R-type, no waits:** opcode 0000, `mem_ready`=1 throughout → state sequence 0,1,6,7,0. `alu_op`=10 in state 6, `reg_write`=`reg_dst`=1 in state 7, `retired`=1.
- **LW with waits:** opcode 0001, `mem_ready`=0 for 2 cycles in FETCH and 3 in MEM_RD → 10 cycles FETCH to FETCH. `ir_write` is high exactly 1 cycle, `mem_to_reg`=1 in state 4.
- **SW then BEQ:**
  - SW: `mem_write` pulses only with `mem_ready`; `reg_write` is never asserted.
  - BEQ: state 8 for 1 cycle with `alu_op`=01 and `pc_write_cond`=1.
- **Illegal opcode:** opcode 1010 → ERROR (13), `error`=1 sticky for 20 cycles despite opcode changes. Reset clears it.
- **HALT and counter wrap:** with `RETIRE_W`=4, execute 16 ADDIs → `retired`=0. Then HALT → `halted`=1 and `retired` is frozen.
